// File: rtl/ram_sp_master_if.sv
// Request/response stream bundle between a client and ram_sp_master.
// The client drives the master modport; ram_sp_master takes the slave modport.
interface ram_sp_master_if #(
  parameter int D_WIDTH = 32,
  parameter int D_DEPTH = 64,
  parameter int BYTE_EN = 0
);
  localparam int AW   = $clog2(D_DEPTH);
  localparam int BE_W = (BYTE_EN != 0) ? D_WIDTH / 8 : 1;

  logic               req_valid_i;
  logic               req_ready_o;
  logic               req_we_i;
  logic [BE_W-1:0]    req_be_i;
  logic [AW-1:0]      req_addr_i;
  logic [D_WIDTH-1:0] req_wdata_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [D_WIDTH-1:0] rsp_rdata_o;

  modport master (
    output req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_be_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o
  );
endinterface

// File: rtl/ram_sp_master.sv
// Single-port RAM initiator: request stream -> RAM cycles, in-order buffered read responses.
// Optional power-up clear of the whole RAM is enabled with `define RAM_SP_MASTER_CLEAR_EN.
module ram_sp_master #(
  parameter int D_WIDTH   = 32,
  parameter int D_DEPTH   = 64,
  parameter int BYTE_EN   = 0,
  parameter int REG_OUT   = 1,
  parameter int RSP_DEPTH = 4,
  localparam int AW   = $clog2(D_DEPTH),
  localparam int BE_W = (BYTE_EN != 0) ? D_WIDTH / 8 : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  ram_sp_master_if.slave     bus,
  output logic [BE_W-1:0]    ram_wr_en_o,
  output logic [D_WIDTH-1:0] ram_wr_data_o,
  output logic [AW-1:0]      ram_rw_addr_o,
  output logic               ram_rd_en_o,
  input  logic [D_WIDTH-1:0] ram_rd_data_i,
  output logic               busy_o
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = $clog2(RSP_DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e             state_q;
  logic [AW-1:0]      clr_addr_q;
  logic               clearing;
  logic               req_ready;
  logic               accept;
  logic               rd_acc;
  logic               push;
  logic               pop;
  logic               rsp_valid;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      fill_q;
  logic [PW-1:0]      wr_ptr_q;
  logic [PW-1:0]      rd_ptr_q;
  logic [D_WIDTH-1:0] fifo_mem [RSP_DEPTH];

`ifdef RAM_SP_MASTER_CLEAR_EN
  logic busy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      clr_addr_q <= clr_addr_q + 1'b1;
      if (clr_addr_q == AW'(D_DEPTH - 1)) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
`else
  assign state_q    = ST_IDLE;
  assign clr_addr_q = '0;
  assign busy_o     = 1'b0;
`endif

  // Count covers reads in flight plus buffered responses, so acceptance alone bounds the FIFO.
  assign clearing  = (state_q == ST_CLEAR) && !rst_i;
  assign req_ready = !rst_i && (state_q == ST_IDLE) && (count_q < CW'(RSP_DEPTH));
  assign accept    = bus.req_valid_i && req_ready;
  assign rd_acc    = accept && !bus.req_we_i;

  assign bus.req_ready_o = req_ready;
  assign ram_rd_en_o     = rd_acc;
  assign ram_rw_addr_o   = clearing ? clr_addr_q : bus.req_addr_i;
  assign ram_wr_data_o   = clearing ? '0 : bus.req_wdata_i;
  assign ram_wr_en_o     = clearing                     ? {BE_W{1'b1}} :
                           (accept && bus.req_we_i)     ? ((BYTE_EN != 0) ? bus.req_be_i : {BE_W{1'b1}}) :
                                                          '0;

  // Stage p1: RAM read data valid one cycle after the read when the RAM output is registered.
  if (REG_OUT != 0) begin : g_reg_out
    logic rd_pend_p1;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rd_pend_p1 <= 1'b0;
      else       rd_pend_p1 <= rd_acc;
    end
    assign push = rd_pend_p1;
  end else begin : g_comb_out
    assign push = rd_acc;
  end

  // Response FIFO: storage carries no reset, only pointers and occupancy do.
  assign rsp_valid       = (fill_q != '0);
  assign pop             = rsp_valid && bus.rsp_ready_i;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_rdata_o = rsp_valid ? fifo_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_rd_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
      case ({rd_acc, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule
